// File: rtl/replay_timer_ctl.sv
// ---------------------------------------------------------------------------
// replay_timer_ctl
//   Data-link TX replay timer with REPLAY_NUM tracking. Times outstanding
//   TLPs, requests a replay on timeout or NAK, counts consecutive replays and
//   requests a link retrain when REPLAY_NUM rolls over.
//
// Optional feature macro: REPLAY_TMR_STATS_EN
//   When defined, adds parameter STAT_W and output timeout_total, a
//   saturating count of timer expiries (NAK replays are not counted).
//
// Ports
//   clk            clock
//   rst            synchronous active-low reset
//   dl_down        link layer down
//   link_train     link training in progress (freezes the timer)
//   ack_fwd        ACK with forward progress (pulse)
//   nak_fwd        NAK with forward progress (pulse)
//   replay_done    replay buffer finished retransmission (pulse)
//   unack_cnt      TLPs awaiting ACK
//   timeout_limit  programmed limit in cycles, 0 selects TIMEOUT_DEF
//   time_out       1-cycle timeout pulse
//   replay_req     1-cycle replay request pulse (timeout or NAK)
//   retrain_req    1-cycle retrain request pulse (REPLAY_NUM rollover)
//   replay_num     current REPLAY_NUM
//   timer          current timer value
//   busy           timer is running
//   timeout_total  saturating timeout count (REPLAY_TMR_STATS_EN only)
// ---------------------------------------------------------------------------
module replay_timer_ctl #(
  parameter int unsigned TMR_W       = 15,
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned RN_W        = 2,
  parameter int unsigned TIMEOUT_DEF = 31000
`ifdef REPLAY_TMR_STATS_EN
  ,
  parameter int unsigned STAT_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dl_down,
  input  logic             link_train,
  input  logic             ack_fwd,
  input  logic             nak_fwd,
  input  logic             replay_done,
  input  logic [CNT_W-1:0] unack_cnt,
  input  logic [TMR_W-1:0] timeout_limit,
  output logic             time_out,
  output logic             replay_req,
  output logic             retrain_req,
  output logic [RN_W-1:0]  replay_num,
  output logic [TMR_W-1:0] timer,
  output logic             busy
`ifdef REPLAY_TMR_STATS_EN
  ,
  output logic [STAT_W-1:0] timeout_total
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPLAY = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [RN_W-1:0]   replay_num_q, replay_num_d;
  logic              time_out_q, time_out_d;
  logic              replay_req_q, replay_req_d;
  logic              retrain_q, retrain_d;
  logic              busy_q, busy_d;

  logic [TMR_W-1:0]  eff_lim_c;
  logic [TMR_W-1:0]  lim_m1_c;
  logic              has_unack_c;
  logic              fire_c;

  // Effective limit is re-evaluated every cycle; >= compare makes a lowered
  // limit fire on the next RUN cycle instead of waiting for a wrap.
  assign eff_lim_c   = (timeout_limit != '0) ? timeout_limit : TMR_W'(TIMEOUT_DEF);
  assign lim_m1_c    = eff_lim_c - TMR_W'(1);
  assign has_unack_c = (unack_cnt != '0);

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      replay_num_q <= '0;
      time_out_q   <= 1'b0;
      replay_req_q <= 1'b0;
      retrain_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      replay_num_q <= replay_num_d;
      time_out_q   <= time_out_d;
      replay_req_q <= replay_req_d;
      retrain_q    <= retrain_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    replay_num_d = replay_num_q;
    time_out_d   = 1'b0;
    replay_req_d = 1'b0;
    retrain_d    = 1'b0;
    fire_c       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (has_unack_c && !dl_down && !link_train) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (dl_down) begin
          state_d      = ST_IDLE;
          timer_d      = '0;
          replay_num_d = '0;
        end else if (ack_fwd) begin
          // Forward progress restarts timing; a same-cycle NAK is dropped.
          timer_d      = '0;
          replay_num_d = '0;
          state_d      = has_unack_c ? ST_RUN : ST_IDLE;
        end else if (nak_fwd) begin
          fire_c = 1'b1;
        end else if (timer_q >= lim_m1_c) begin
          time_out_d = 1'b1;
          fire_c     = 1'b1;
        end else if (link_train) begin
          state_d = ST_HOLD;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_REPLAY: begin
        timer_d = '0;
        if (dl_down) begin
          state_d      = ST_IDLE;
          replay_num_d = '0;
        end else if (ack_fwd) begin
          replay_num_d = '0;
        end else if (replay_done) begin
          state_d = has_unack_c ? ST_RUN : ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (dl_down) begin
          state_d      = ST_IDLE;
          timer_d      = '0;
          replay_num_d = '0;
        end else if (ack_fwd) begin
          timer_d      = '0;
          replay_num_d = '0;
        end else if (!link_train) begin
          if (has_unack_c) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        end
      end
    endcase

    // Common replay launch for NAK and timeout; retrain on REPLAY_NUM wrap.
    if (fire_c) begin
      replay_req_d = 1'b1;
      retrain_d    = &replay_num_q;
      replay_num_d = replay_num_q + RN_W'(1);
      timer_d      = '0;
      state_d      = ST_REPLAY;
    end
  end

  assign busy_d = (state_d == ST_RUN);

  assign time_out    = time_out_q;
  assign replay_req  = replay_req_q;
  assign retrain_req = retrain_q;
  assign replay_num  = replay_num_q;
  assign timer       = timer_q;
  assign busy        = busy_q;

`ifdef REPLAY_TMR_STATS_EN
  logic [STAT_W-1:0] total_q;

  // Saturating timeout counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      total_q <= '0;
    end else if (time_out_d && (total_q != '1)) begin
      total_q <= total_q + STAT_W'(1);
    end
  end

  assign timeout_total = total_q;
`endif

endmodule
